// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller and its perf counters.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERR      = 2'b10
  } hazard_state_t;

  localparam int CNT_W_DEFAULT       = 32;
  localparam int MEM_TIMEOUT_DEFAULT = 255;
  localparam int TO_W_DEFAULT        = 8;

endpackage

// File: rtl/hazard_perf_counter.sv
// Free-running enable-increment counter with synchronous active-low clear.
// Wraps modulo 2^W.
module hazard_perf_counter
  import hazard_pkg::*;
#(
  parameter int W = CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en,
  output logic [W-1:0] count
);

  // Clear has priority; otherwise count one per enabled cycle.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core.
// Handles the hazards forwarding cannot resolve (load-use, EX-stage
// mispredicts, multi-cycle data-memory accesses with a watchdog) and
// keeps hazard performance counters for predictor evaluation.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int TO_W        = TO_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IFID_Rs1,
  input  logic [4:0]       IFID_Rs2,
  input  logic             IFID_UseRs1,
  input  logic             IFID_UseRs2,
  input  logic [4:0]       IDEX_Rd,
  input  logic             IDEX_MemRd,
  input  logic             EX_Mispredict,
  input  logic             EXMEM_MemReq,
  input  logic             DmemReady,
  output logic             PC_En,
  output logic             IFID_En,
  output logic             IDEX_En,
  output logic             EXMEM_En,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             MEMWB_Flush,
  output logic             PC_Redirect,
  output logic             DmemValid,
  output logic             MemTimeoutErr,
  output logic [CNT_W-1:0] LoadUseCnt,
  output logic [CNT_W-1:0] MispredCnt,
  output logic [CNT_W-1:0] MemWaitCnt
);

  // Wait-counter value seen during the last allowed frozen MEM_WAIT cycle.
  localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);

  hazard_state_t   state;
  logic [TO_W-1:0] wait_cnt;

  logic in_err;
  logic freeze;
  logic load_use_hit;
  logic mispredict_svc;
  logic load_use_stall;

  assign in_err = (state == ST_ERR);

  // A pending data-memory access stalls the whole pipe; it outranks
  // everything else because EX is held and its hazards simply wait.
  assign freeze = !in_err && EXMEM_MemReq && !DmemReady;

  assign load_use_hit = IDEX_MemRd && (IDEX_Rd != 5'd0) &&
                        ((IFID_UseRs1 && (IDEX_Rd == IFID_Rs1)) ||
                         (IFID_UseRs2 && (IDEX_Rd == IFID_Rs2)));

  // A mispredict discards the ID instruction, so it masks load-use.
  assign mispredict_svc = !in_err && !freeze && EX_Mispredict;
  assign load_use_stall = !in_err && !freeze && !EX_Mispredict && load_use_hit;

  assign MemTimeoutErr = in_err;
  assign DmemValid     = !in_err && EXMEM_MemReq;

  // Priority encode the hazard response into enables, flushes and redirect.
  always_comb begin
    PC_En       = 1'b1;
    IFID_En     = 1'b1;
    IDEX_En     = 1'b1;
    EXMEM_En    = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    MEMWB_Flush = 1'b0;
    PC_Redirect = 1'b0;
    if (in_err) begin
      PC_En    = 1'b0;
      IFID_En  = 1'b0;
      IDEX_En  = 1'b0;
      EXMEM_En = 1'b0;
    end else if (freeze) begin
      PC_En       = 1'b0;
      IFID_En     = 1'b0;
      IDEX_En     = 1'b0;
      EXMEM_En    = 1'b0;
      MEMWB_Flush = 1'b1;
    end else if (mispredict_svc) begin
      PC_Redirect = 1'b1;
      IFID_Flush  = 1'b1;
      IDEX_Flush  = 1'b1;
    end else if (load_use_stall) begin
      PC_En      = 1'b0;
      IFID_En    = 1'b0;
      IDEX_Flush = 1'b1;
    end
  end

  // Sequencing FSM plus saturating wait counter for the memory watchdog.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          wait_cnt <= '0;
          if (freeze) begin
            state <= ST_MEM_WAIT;
          end
        end
        ST_MEM_WAIT: begin
          if (!freeze) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else begin
            if (wait_cnt == WAIT_LAST) begin
              state <= ST_ERR;
            end
            if (wait_cnt != {TO_W{1'b1}}) begin
              wait_cnt <= wait_cnt + TO_W'(1);
            end
          end
        end
        ST_ERR: begin
          state <= ST_ERR;
        end
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  hazard_perf_counter #(.W(CNT_W)) u_load_use_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .en    (load_use_stall),
    .count (LoadUseCnt)
  );

  hazard_perf_counter #(.W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .en    (mispredict_svc),
    .count (MispredCnt)
  );

  hazard_perf_counter #(.W(CNT_W)) u_mem_wait_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .en    (freeze),
    .count (MemWaitCnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl with a small counter width
// and short watchdog so wrap and timeout are reachable quickly.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 4;
  localparam int TO_W        = 8;
  localparam int CNT_MOD     = 1 << CNT_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] IFID_Rs1 = '0, IFID_Rs2 = '0, IDEX_Rd = '0;
  logic IFID_UseRs1 = 0, IFID_UseRs2 = 0, IDEX_MemRd = 0;
  logic EX_Mispredict = 0, EXMEM_MemReq = 0, DmemReady = 0;

  logic PC_En, IFID_En, IDEX_En, EXMEM_En;
  logic IFID_Flush, IDEX_Flush, MEMWB_Flush, PC_Redirect;
  logic DmemValid, MemTimeoutErr;
  logic [CNT_W-1:0] LoadUseCnt, MispredCnt, MemWaitCnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: error flag, length of the current run of
  // consecutive frozen cycles, and the three event tallies.
  bit m_err = 0;
  int m_frozen_run = 0;
  int m_lu = 0, m_mp = 0, m_mw = 0;

  pipeline_hazard_ctrl #(
    .CNT_W       (CNT_W),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TO_W        (TO_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .IFID_Rs1      (IFID_Rs1),
    .IFID_Rs2      (IFID_Rs2),
    .IFID_UseRs1   (IFID_UseRs1),
    .IFID_UseRs2   (IFID_UseRs2),
    .IDEX_Rd       (IDEX_Rd),
    .IDEX_MemRd    (IDEX_MemRd),
    .EX_Mispredict (EX_Mispredict),
    .EXMEM_MemReq  (EXMEM_MemReq),
    .DmemReady     (DmemReady),
    .PC_En         (PC_En),
    .IFID_En       (IFID_En),
    .IDEX_En       (IDEX_En),
    .EXMEM_En      (EXMEM_En),
    .IFID_Flush    (IFID_Flush),
    .IDEX_Flush    (IDEX_Flush),
    .MEMWB_Flush   (MEMWB_Flush),
    .PC_Redirect   (PC_Redirect),
    .DmemValid     (DmemValid),
    .MemTimeoutErr (MemTimeoutErr),
    .LoadUseCnt    (LoadUseCnt),
    .MispredCnt    (MispredCnt),
    .MemWaitCnt    (MemWaitCnt)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Classify the current cycle from the hazard rules.
  task automatic classify(output bit frz, output bit mp, output bit lu);
    bit hit;
    hit = IDEX_MemRd && (IDEX_Rd != 5'd0) &&
          ((IFID_UseRs1 && IDEX_Rd == IFID_Rs1) || (IFID_UseRs2 && IDEX_Rd == IFID_Rs2));
    frz = !m_err && EXMEM_MemReq && !DmemReady;
    mp  = !m_err && !frz && EX_Mispredict;
    lu  = !m_err && !frz && !EX_Mispredict && hit;
  endtask

  // Compare every DUT output against what the model says this cycle needs.
  task automatic checkOutput();
    bit frz, mp, lu;
    bit e_pc, e_ifid, e_idex, e_exmem, f_ifid, f_idex, f_memwb, redir;
    classify(frz, mp, lu);
    e_pc = 1; e_ifid = 1; e_idex = 1; e_exmem = 1;
    f_ifid = 0; f_idex = 0; f_memwb = 0; redir = 0;
    if (m_err) begin
      e_pc = 0; e_ifid = 0; e_idex = 0; e_exmem = 0;
    end else if (frz) begin
      e_pc = 0; e_ifid = 0; e_idex = 0; e_exmem = 0; f_memwb = 1;
    end else if (mp) begin
      redir = 1; f_ifid = 1; f_idex = 1;
    end else if (lu) begin
      e_pc = 0; e_ifid = 0; f_idex = 1;
    end
    checkVal("PC_En", 32'(PC_En), 32'(e_pc));
    checkVal("IFID_En", 32'(IFID_En), 32'(e_ifid));
    checkVal("IDEX_En", 32'(IDEX_En), 32'(e_idex));
    checkVal("EXMEM_En", 32'(EXMEM_En), 32'(e_exmem));
    checkVal("IFID_Flush", 32'(IFID_Flush), 32'(f_ifid));
    checkVal("IDEX_Flush", 32'(IDEX_Flush), 32'(f_idex));
    checkVal("MEMWB_Flush", 32'(MEMWB_Flush), 32'(f_memwb));
    checkVal("PC_Redirect", 32'(PC_Redirect), 32'(redir));
    checkVal("DmemValid", 32'(DmemValid), 32'(!m_err && EXMEM_MemReq));
    checkVal("MemTimeoutErr", 32'(MemTimeoutErr), 32'(m_err));
    checkVal("LoadUseCnt", 32'(LoadUseCnt), 32'(m_lu));
    checkVal("MispredCnt", 32'(MispredCnt), 32'(m_mp));
    checkVal("MemWaitCnt", 32'(MemWaitCnt), 32'(m_mw));
  endtask

  // Advance the model across a clock edge using the inputs held before it.
  task automatic updateModel();
    bit frz, mp, lu;
    if (!rst_n) begin
      m_err = 0; m_frozen_run = 0; m_lu = 0; m_mp = 0; m_mw = 0;
    end else if (!m_err) begin
      classify(frz, mp, lu);
      if (mp) m_mp = (m_mp + 1) % CNT_MOD;
      if (lu) m_lu = (m_lu + 1) % CNT_MOD;
      if (frz) begin
        m_mw = (m_mw + 1) % CNT_MOD;
        m_frozen_run++;
        if (m_frozen_run == MEM_TIMEOUT + 1) m_err = 1;
      end else begin
        m_frozen_run = 0;
      end
    end
  endtask

  // One cycle: cross the edge, drive new inputs, check mid-cycle.
  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2,
                               input logic [4:0] rd, input logic memrd,
                               input logic mp, input logic mreq, input logic rdy);
    @(posedge clk);
    updateModel();
    #1;
    rst_n = 1'b1;
    IFID_Rs1 = rs1; IFID_Rs2 = rs2; IFID_UseRs1 = u1; IFID_UseRs2 = u2;
    IDEX_Rd = rd; IDEX_MemRd = memrd; EX_Mispredict = mp;
    EXMEM_MemReq = mreq; DmemReady = rdy;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
  endtask

  // One cycle with rst_n low and quiet inputs; exactly one reset edge follows.
  task automatic doReset();
    @(posedge clk);
    updateModel();
    #1;
    rst_n = 1'b0;
    IFID_Rs1 = '0; IFID_Rs2 = '0; IFID_UseRs1 = 0; IFID_UseRs2 = 0;
    IDEX_Rd = '0; IDEX_MemRd = 0; EX_Mispredict = 0;
    EXMEM_MemReq = 0; DmemReady = 0;
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    idle();
    checkVal("lit_reset_LoadUseCnt", 32'(LoadUseCnt), 32'd0);
    checkVal("lit_reset_Err", 32'(MemTimeoutErr), 32'd0);
    checkVal("lit_reset_PC_En", 32'(PC_En), 32'd1);

    // Load x5 in EX, ID reads x5 through Rs2: one bubble
    applyStimulus(5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0);
    checkVal("lit_lu_PC_En", 32'(PC_En), 32'd0);
    checkVal("lit_lu_IDEX_Flush", 32'(IDEX_Flush), 32'd1);
    idle();
    checkVal("lit_lu_count", 32'(LoadUseCnt), 32'd1);
    // Rd = x0 never stalls
    applyStimulus(5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0);
    checkVal("lit_rd0_PC_En", 32'(PC_En), 32'd1);
    // Register match but Rs2 not actually read
    applyStimulus(5'd0, 5'd5, 0, 0, 5'd5, 1, 0, 0, 0);
    checkVal("lit_nouse_IFID_En", 32'(IFID_En), 32'd1);
    // Match through Rs1
    applyStimulus(5'd7, 5'd1, 1, 0, 5'd7, 1, 0, 0, 0);
    idle();
    checkVal("lit_lu_count2", 32'(LoadUseCnt), 32'd2);

    // Mispredict together with load-use: mispredict wins
    doReset();
    applyStimulus(5'd0, 5'd5, 0, 1, 5'd5, 1, 1, 0, 0);
    checkVal("lit_mp_Redirect", 32'(PC_Redirect), 32'd1);
    checkVal("lit_mp_PC_En", 32'(PC_En), 32'd1);
    idle();
    checkVal("lit_mp_MispredCnt", 32'(MispredCnt), 32'd1);
    checkVal("lit_mp_LoadUseCnt", 32'(LoadUseCnt), 32'd0);

    // Three-cycle memory wait, advance on the fourth
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
      checkVal("lit_frz_MEMWB_Flush", 32'(MEMWB_Flush), 32'd1);
      checkVal("lit_frz_DmemValid", 32'(DmemValid), 32'd1);
    end
    applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1);
    checkVal("lit_frz_release_PC_En", 32'(PC_En), 32'd1);
    idle();
    checkVal("lit_frz_MemWaitCnt", 32'(MemWaitCnt), 32'd3);
    applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
    applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1);

    // Mispredict held through a two-cycle freeze
    doReset();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0);
      checkVal("lit_mpfrz_Redirect", 32'(PC_Redirect), 32'd0);
    end
    applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 1);
    checkVal("lit_mpfrz_Redirect_rel", 32'(PC_Redirect), 32'd1);
    checkVal("lit_mpfrz_IFID_Flush", 32'(IFID_Flush), 32'd1);
    idle();
    checkVal("lit_mpfrz_MispredCnt", 32'(MispredCnt), 32'd1);
    checkVal("lit_mpfrz_MemWaitCnt", 32'(MemWaitCnt), 32'd2);

    // Ready in the same cycle as the request: zero wait cycles
    doReset();
    applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1);
    checkVal("lit_zw_PC_En", 32'(PC_En), 32'd1);
    idle();
    checkVal("lit_zw_MemWaitCnt", 32'(MemWaitCnt), 32'd0);

    // Watchdog: one RUN frozen cycle plus MEM_TIMEOUT MEM_WAIT cycles
    doReset();
    for (int i = 0; i < MEM_TIMEOUT + 1; i++) begin
      applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
    end
    applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
    checkVal("lit_err_flag", 32'(MemTimeoutErr), 32'd1);
    checkVal("lit_err_DmemValid", 32'(DmemValid), 32'd0);
    applyStimulus(5'd0, 5'd5, 0, 1, 5'd5, 1, 1, 1, 1);
    applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
    checkVal("lit_err_sticky", 32'(MemTimeoutErr), 32'd1);
    checkVal("lit_err_MemWaitCnt", 32'(MemWaitCnt), 32'd5);
    checkVal("lit_err_MispredCnt", 32'(MispredCnt), 32'd0);
    doReset();
    idle();
    checkVal("lit_rst_err_cleared", 32'(MemTimeoutErr), 32'd0);
    checkVal("lit_rst_MemWaitCnt", 32'(MemWaitCnt), 32'd0);
    checkVal("lit_rst_PC_En", 32'(PC_En), 32'd1);

    // Counter wrap at 2^CNT_W load-use events
    doReset();
    for (int i = 0; i < 15; i++) begin
      applyStimulus(5'd3, 5'd0, 1, 0, 5'd3, 1, 0, 0, 0);
    end
    idle();
    checkVal("lit_wrap_15", 32'(LoadUseCnt), 32'd15);
    applyStimulus(5'd3, 5'd0, 1, 0, 5'd3, 1, 0, 0, 0);
    idle();
    checkVal("lit_wrap_0", 32'(LoadUseCnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
